paper_processor_core: RTL

Parametrised single-clock paper processor: a synthesizable core generalised from the 2-bit INC/JNO/HLT machine. It holds an internal program memory and runs a two-phase FETCH/EXECUTE sequence. It adds DEC, JMP and CLR instructions, illegal-opcode fault, a step watchdog, and a start/busy/halted handshake. The core sits under the processor testbench in place of the discrete memory/pc/increment/jno/halt cells.

---
 rtl/pp_pkg.sv | 20 ++
 rtl/pp_program_mem.sv | 23 ++
 rtl/paper_processor_core.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pp_pkg.sv
// rtl/pp_pkg.sv - shared opcode, state and field-width definitions for the paper processor core
package pp_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_INC = 3'b000;
  localparam logic [OPC_W-1:0] OP_JNO = 3'b001;
  localparam logic [OPC_W-1:0] OP_HLT = 3'b010;
  localparam logic [OPC_W-1:0] OP_DEC = 3'b011;
  localparam logic [OPC_W-1:0] OP_JMP = 3'b100;
  localparam logic [OPC_W-1:0] OP_CLR = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pp_program_mem.sv
// rtl/pp_program_mem.sv - program store with synchronous write and asynchronous read
module pp_program_mem #(
  parameter int ADDR_W = 2,
  parameter int WORD_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // No reset: a loaded program survives a core reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/paper_processor_core.sv
// rtl/paper_processor_core.sv - two-phase fetch/execute paper processor with fault and watchdog halts
module paper_processor_core
  import pp_pkg::*;
#(
  parameter int DATA_W    = 2,
  parameter int ADDR_W    = 2,
  parameter int MAX_STEPS = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           prog_we,
  input  logic [ADDR_W-1:0]              prog_addr,
  input  logic [OPC_W+ADDR_W-1:0]        prog_data,
  input  logic                           start,
  output logic                           busy,
  output logic                           halted,
  output logic [ADDR_W-1:0]              pc,
  output logic [DATA_W-1:0]              acc,
  output logic                           status,
  output logic [$clog2(MAX_STEPS+1)-1:0] instr_count,
  output logic                           fault,
  output logic                           timeout
);

  localparam int CNT_W   = $clog2(MAX_STEPS+1);
  localparam int INSTR_W = OPC_W + ADDR_W;

  state_t              state;
  logic [INSTR_W-1:0]  ir;
  logic [INSTR_W-1:0]  mem_word;
  logic                mem_we;
  logic [OPC_W-1:0]    opcode;
  logic [ADDR_W-1:0]   operand;
  logic [CNT_W-1:0]    count_next;
  logic                stop_now;
  logic                bad_op;

  // Writes are only honoured while the core is not running a program.
  assign mem_we = prog_we && (state == IDLE || state == HALTED);

  pp_program_mem #(
    .ADDR_W (ADDR_W),
    .WORD_W (INSTR_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (mem_word)
  );

  assign opcode     = ir[INSTR_W-1 -: OPC_W];
  assign operand    = ir[ADDR_W-1:0];
  assign count_next = instr_count + CNT_W'(1);
  assign bad_op     = (opcode == 3'b110) || (opcode == 3'b111);
  assign stop_now   = (opcode == OP_HLT) || bad_op;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      ir          <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      pc          <= '0;
      acc         <= '0;
      status      <= 1'b0;
      instr_count <= '0;
      fault       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            halted      <= 1'b0;
            pc          <= '0;
            acc         <= '0;
            status      <= 1'b0;
            instr_count <= '0;
            fault       <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        FETCH: begin
          ir    <= mem_word;
          state <= EXEC;
        end
        EXEC: begin
          instr_count <= count_next;
          pc          <= pc + ADDR_W'(1);
          case (opcode)
            OP_INC: if (!status) {status, acc} <= {1'b0, acc} + (DATA_W+1)'(1);
            OP_JNO: if (!status) pc <= operand;
            OP_HLT: pc <= pc;
            OP_DEC: begin
              if (!status) begin
                acc    <= acc - DATA_W'(1);
                status <= (acc == '0);
              end
            end
            OP_JMP: pc <= operand;
            OP_CLR: begin
              acc    <= '0;
              status <= 1'b0;
            end
            default: begin
              pc    <= pc;
              fault <= 1'b1;
            end
          endcase
          if (stop_now) begin
            state  <= HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (count_next == CNT_W'(MAX_STEPS)) begin
            state   <= HALTED;
            busy    <= 1'b0;
            halted  <= 1'b1;
            timeout <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
